// File: rtl/usb2_packet_rx_if.sv
// Receive-side bus of usb2_packet_rx: ULPI byte stream in, decoded packet events out.
// master = ULPI stage / consumer side, slave = the packet decoder.
interface usb2_packet_rx_if;
  logic        in_act;
  logic [7:0]  in_byte;
  logic        in_latch;

  logic        tok_strobe;
  logic [3:0]  tok_pid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [10:0] sof_frame;
  logic        data_valid;
  logic [7:0]  data_byte;
  logic [3:0]  data_pid;
  logic        data_done;
  logic        data_good;
  logic        hsk_strobe;
  logic [3:0]  hsk_pid;
  logic        err_strobe;

  modport master (
    output in_act, in_byte, in_latch,
    input  tok_strobe, tok_pid, tok_addr, tok_endp, sof_frame,
    input  data_valid, data_byte, data_pid, data_done, data_good,
    input  hsk_strobe, hsk_pid, err_strobe
  );

  modport slave (
    input  in_act, in_byte, in_latch,
    output tok_strobe, tok_pid, tok_addr, tok_endp, sof_frame,
    output data_valid, data_byte, data_pid, data_done, data_good,
    output hsk_strobe, hsk_pid, err_strobe
  );
endinterface

// File: rtl/usb2_packet_rx.sv
// USB2 packet decoder: splits a ULPI byte stream into token/SOF, data and handshake events.
// Define USB2_PACKET_RX_CRC16_EN to check the CRC16 of data packets; CRC5 is always checked.
module usb2_packet_rx (
  input logic             phy_clk,
  input logic             reset,
  usb2_packet_rx_if.slave bus
);

  // 1024 payload bytes plus the two CRC16 bytes
  localparam logic [10:0] MaxBytes     = 11'd1026;
  localparam logic [4:0]  Crc5Residual = 5'b01100;
  localparam logic [3:0]  PidSof       = 4'b0101;

  typedef enum logic [2:0] {
    StIdle, StTok1, StTok2, StData, StHsk, StEnd, StDiscard
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  hold0_q, hold0_d;
  logic [7:0]  hold1_q, hold1_d;
  logic [4:0]  crc5_q, crc5_d;
  logic        tok_strobe_q, tok_strobe_d;
  logic [3:0]  tok_pid_q, tok_pid_d;
  logic [6:0]  tok_addr_q, tok_addr_d;
  logic [3:0]  tok_endp_q, tok_endp_d;
  logic [10:0] sof_frame_q, sof_frame_d;
  logic        data_valid_q, data_valid_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic [3:0]  data_pid_q, data_pid_d;
  logic        data_done_q, data_done_d;
  logic        data_good_q, data_good_d;
  logic        hsk_strobe_q, hsk_strobe_d;
  logic [3:0]  hsk_pid_q, hsk_pid_d;
  logic        err_strobe_q, err_strobe_d;
  logic        byte_in, accept, crc_ok;

  // Serial CRC, bits consumed LSB-first as on the wire
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (b[i] ^ c[4]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
    end
    return c;
  endfunction

`ifdef USB2_PACKET_RX_CRC16_EN
  logic [15:0] crc16_q, crc16_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (b[i] ^ c[15]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_ok = (crc16_q == 16'h800D);

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) crc16_q <= 16'h0000;
    else       crc16_q <= crc16_d;
  end
`else
  assign crc_ok = 1'b1;
`endif

  assign byte_in = bus.in_act & bus.in_latch;

  always_comb begin
    state_d      = state_q;
    // After reset, bytes are ignored until in_act has been seen low once
    armed_d      = armed_q | ~bus.in_act;
    pid_d        = pid_q;
    cnt_d        = cnt_q;
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    crc5_d       = crc5_q;
`ifdef USB2_PACKET_RX_CRC16_EN
    crc16_d      = crc16_q;
`endif
    accept       = 1'b0;
    tok_strobe_d = 1'b0;
    tok_pid_d    = tok_pid_q;
    tok_addr_d   = tok_addr_q;
    tok_endp_d   = tok_endp_q;
    sof_frame_d  = sof_frame_q;
    data_valid_d = 1'b0;
    data_byte_d  = data_byte_q;
    data_pid_d   = data_pid_q;
    data_done_d  = 1'b0;
    data_good_d  = data_good_q;
    hsk_strobe_d = 1'b0;
    hsk_pid_d    = hsk_pid_q;
    err_strobe_d = 1'b0;

    case (state_q)
      StIdle, StEnd: begin
        state_d = StIdle;
        if (byte_in && armed_q) begin
          pid_d  = bus.in_byte[3:0];
          cnt_d  = '0;
          crc5_d = 5'h1f;
`ifdef USB2_PACKET_RX_CRC16_EN
          crc16_d = 16'hFFFF;
`endif
          if (bus.in_byte[7:4] != ~bus.in_byte[3:0]) begin
            state_d      = StDiscard;
            err_strobe_d = 1'b1;
          end else begin
            case (bus.in_byte[3:0])
              4'b0001, 4'b1001, 4'b0101, 4'b1101, 4'b0100: state_d = StTok1;
              4'b0011, 4'b1011, 4'b0111, 4'b1111: begin
                state_d    = StData;
                data_pid_d = bus.in_byte[3:0];
              end
              4'b0010, 4'b1010, 4'b1110, 4'b0110: state_d = StHsk;
              default: begin
                state_d      = StDiscard;
                err_strobe_d = 1'b1;
              end
            endcase
          end
        end
      end

      StTok1: begin
        if (!bus.in_act) begin
          err_strobe_d = 1'b1;
          state_d      = StEnd;
        end else if (byte_in) begin
          accept  = 1'b1;
          state_d = StTok2;
        end
      end

      StTok2: begin
        if (!bus.in_act) begin
          state_d = StEnd;
          if (cnt_q == 11'd2 && crc5_q == Crc5Residual) begin
            tok_strobe_d = 1'b1;
            tok_pid_d    = pid_q;
            if (pid_q == PidSof) begin
              sof_frame_d = {hold1_q[2:0], hold0_q};
            end else begin
              tok_addr_d = hold0_q[6:0];
              tok_endp_d = {hold1_q[2:0], hold0_q[7]};
            end
          end else begin
            err_strobe_d = 1'b1;
          end
        end else if (byte_in) begin
          if (cnt_q == 11'd2) begin
            state_d      = StDiscard;
            err_strobe_d = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
      end

      StHsk: begin
        if (!bus.in_act) begin
          hsk_strobe_d = 1'b1;
          hsk_pid_d    = pid_q;
          state_d      = StEnd;
        end else if (byte_in) begin
          state_d      = StDiscard;
          err_strobe_d = 1'b1;
        end
      end

      StData: begin
        if (!bus.in_act) begin
          data_done_d  = 1'b1;
          data_good_d  = (cnt_q >= 11'd2) && crc_ok;
          err_strobe_d = (cnt_q < 11'd2);
          state_d      = StEnd;
        end else if (byte_in) begin
          if (cnt_q == MaxBytes) begin
            data_done_d  = 1'b1;
            data_good_d  = 1'b0;
            err_strobe_d = 1'b1;
            state_d      = StDiscard;
          end else begin
            accept = 1'b1;
            // Two-byte lag keeps the trailing CRC16 bytes off data_byte
            if (cnt_q >= 11'd2) begin
              data_valid_d = 1'b1;
              data_byte_d  = hold0_q;
            end
          end
        end
      end

      StDiscard: begin
        if (!bus.in_act) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (accept) begin
      hold0_d = hold1_q;
      hold1_d = bus.in_byte;
      cnt_d   = cnt_q + 11'd1;
      crc5_d  = crc5_byte(crc5_q, bus.in_byte);
`ifdef USB2_PACKET_RX_CRC16_EN
      crc16_d = crc16_byte(crc16_q, bus.in_byte);
`endif
    end
  end

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      armed_q      <= 1'b0;
      pid_q        <= '0;
      cnt_q        <= '0;
      hold0_q      <= '0;
      hold1_q      <= '0;
      crc5_q       <= '0;
      tok_strobe_q <= 1'b0;
      tok_pid_q    <= '0;
      tok_addr_q   <= '0;
      tok_endp_q   <= '0;
      sof_frame_q  <= '0;
      data_valid_q <= 1'b0;
      data_byte_q  <= '0;
      data_pid_q   <= '0;
      data_done_q  <= 1'b0;
      data_good_q  <= 1'b0;
      hsk_strobe_q <= 1'b0;
      hsk_pid_q    <= '0;
      err_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      pid_q        <= pid_d;
      cnt_q        <= cnt_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      crc5_q       <= crc5_d;
      tok_strobe_q <= tok_strobe_d;
      tok_pid_q    <= tok_pid_d;
      tok_addr_q   <= tok_addr_d;
      tok_endp_q   <= tok_endp_d;
      sof_frame_q  <= sof_frame_d;
      data_valid_q <= data_valid_d;
      data_byte_q  <= data_byte_d;
      data_pid_q   <= data_pid_d;
      data_done_q  <= data_done_d;
      data_good_q  <= data_good_d;
      hsk_strobe_q <= hsk_strobe_d;
      hsk_pid_q    <= hsk_pid_d;
      err_strobe_q <= err_strobe_d;
    end
  end

  assign bus.tok_strobe = tok_strobe_q;
  assign bus.tok_pid    = tok_pid_q;
  assign bus.tok_addr   = tok_addr_q;
  assign bus.tok_endp   = tok_endp_q;
  assign bus.sof_frame  = sof_frame_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data_byte  = data_byte_q;
  assign bus.data_pid   = data_pid_q;
  assign bus.data_done  = data_done_q;
  assign bus.data_good  = data_good_q;
  assign bus.hsk_strobe = hsk_strobe_q;
  assign bus.hsk_pid    = hsk_pid_q;
  assign bus.err_strobe = err_strobe_q;

endmodule
